// File: rtl/seg_scan_ctrl.sv
// Six-digit multiplexed 7-segment scan controller: per-digit slot timing with
// anti-ghosting blank, frame-synchronous input shadowing and per-digit blinking.
module seg_scan_ctrl #(
    parameter int DIGIT_CYC    = 50_000,
    parameter int BLANK_CYC    = 500,
    parameter int BLINK_FRAMES = 83
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] din,
    input  logic [5:0]  din_mask,
    input  logic [5:0]  din_dp,
    input  logic [5:0]  blink_en,
    output logic [5:0]  sel,
    output logic [7:0]  seg,
    output logic        frame_done
);

    localparam int CW = (DIGIT_CYC > 1) ? $clog2(DIGIT_CYC) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_CYC - 1);
    localparam logic [CW-1:0] BLANK_LIM  = CW'(BLANK_CYC);
    localparam logic [FW-1:0] FCNT_LAST  = FW'(BLINK_FRAMES - 1);

    function automatic logic [6:0] decode7(input logic [3:0] nib);
        case (nib)
            4'h0:    decode7 = 7'h40;
            4'h1:    decode7 = 7'h79;
            4'h2:    decode7 = 7'h24;
            4'h3:    decode7 = 7'h30;
            4'h4:    decode7 = 7'h19;
            4'h5:    decode7 = 7'h12;
            4'h6:    decode7 = 7'h02;
            4'h7:    decode7 = 7'h78;
            4'h8:    decode7 = 7'h00;
            4'h9:    decode7 = 7'h10;
            4'hA:    decode7 = 7'h08;
            4'hB:    decode7 = 7'h03;
            4'hC:    decode7 = 7'h46;
            4'hD:    decode7 = 7'h21;
            4'hE:    decode7 = 7'h06;
            4'hF:    decode7 = 7'h0E;
            default: decode7 = 7'h7F;
        endcase
    endfunction

    function automatic logic [3:0] nibble_of(input logic [23:0] word, input logic [2:0] i);
        case (i)
            3'd0:    nibble_of = word[3:0];
            3'd1:    nibble_of = word[7:4];
            3'd2:    nibble_of = word[11:8];
            3'd3:    nibble_of = word[15:12];
            3'd4:    nibble_of = word[19:16];
            3'd5:    nibble_of = word[23:20];
            default: nibble_of = 4'h0;
        endcase
    endfunction

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;
    logic [23:0]   din_q, din_d;
    logic [5:0]    mask_q, mask_d;
    logic [5:0]    dp_q, dp_d;
    logic [5:0]    blink_q, blink_d;
    logic [5:0]    sel_q, sel_d;
    logic [7:0]    seg_q, seg_d;
    logic          fd_q, fd_d;

    logic          slot_end_s;
    logic          frame_end_s;
    logic          blank_s;
    logic [5:0]    one_hot_s;

    // Next-state for slot/frame counters, shadow capture and output decode.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        din_d   = din_q;
        mask_d  = mask_q;
        dp_d    = dp_q;
        blink_d = blink_q;
        sel_d   = 6'h3F;
        seg_d   = 8'hFF;
        fd_d    = 1'b0;

        slot_end_s  = (cnt_q == CNT_LAST);
        frame_end_s = slot_end_s && (idx_q == 3'd5);
        one_hot_s   = 6'b00_0001 << idx_q;

        if (slot_end_s) begin
            cnt_d = {CW{1'b0}};
            if (idx_q == 3'd5) begin
                idx_d = 3'd0;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end else begin
            cnt_d = cnt_q + CW'(1);
        end

        // Inputs are only sampled at the very top of a frame, so a frame never tears.
        if ((cnt_q == {CW{1'b0}}) && (idx_q == 3'd0)) begin
            din_d   = din;
            mask_d  = din_mask;
            dp_d    = din_dp;
            blink_d = blink_en;
        end else begin
            din_d   = din_q;
        end

        if (frame_end_s) begin
            fd_d = 1'b1;
            if (fcnt_q == FCNT_LAST) begin
                fcnt_d  = {FW{1'b0}};
                phase_d = ~phase_q;
            end else begin
                fcnt_d  = fcnt_q + FW'(1);
            end
        end else begin
            fd_d = 1'b0;
        end

        blank_s = (cnt_q < BLANK_LIM) || ((mask_q & one_hot_s) == 6'h00)
                  || (((blink_q & one_hot_s) != 6'h00) && phase_q);

        if (blank_s) begin
            sel_d = 6'h3F;
            seg_d = 8'hFF;
        end else begin
            sel_d = ~one_hot_s;
            seg_d = {((dp_q & one_hot_s) == 6'h00), decode7(nibble_of(din_q, idx_q))};
        end
    end

    // State and registered outputs; reset blanks the display immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= {CW{1'b0}};
            idx_q   <= 3'd0;
            fcnt_q  <= {FW{1'b0}};
            phase_q <= 1'b0;
            din_q   <= 24'h00_0000;
            mask_q  <= 6'h00;
            dp_q    <= 6'h00;
            blink_q <= 6'h00;
            sel_q   <= 6'h3F;
            seg_q   <= 8'hFF;
            fd_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
            din_q   <= din_d;
            mask_q  <= mask_d;
            dp_q    <= dp_d;
            blink_q <= blink_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            fd_q    <= fd_d;
        end
    end

    assign sel        = sel_q;
    assign seg        = seg_q;
    assign frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed, table-driven bench for seg_scan_ctrl at DIGIT_CYC=8, BLANK_CYC=2,
// BLINK_FRAMES=2, plus hand sequences for tearing, blinking and mid-frame reset.
module tb_seg_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic [23:0] din;
    logic [5:0]  din_mask;
    logic [5:0]  din_dp;
    logic [5:0]  blink_en;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg_scan_ctrl #(
        .DIGIT_CYC   (8),
        .BLANK_CYC   (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_mask  (din_mask),
        .din_dp    (din_dp),
        .blink_en  (blink_en),
        .sel       (sel),
        .seg       (seg),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp[i] = segment byte expected in slot i; 8'hFF marks a blanked slot
    typedef struct packed {
        logic [23:0]     din;
        logic [5:0]      mask;
        logic [5:0]      dp;
        logic [5:0]      blink;
        logic [5:0][7:0] exp;
    } vec_t;

    vec_t vecs [6];

    localparam logic [47:0] E_123456    = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
    localparam logic [47:0] E_123456_DP = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h02};
    localparam logic [47:0] E_ABCDEF    = {8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    localparam logic [47:0] E_MASKED    = {8'hF9, 8'hA4, 8'hFF, 8'hFF, 8'h92, 8'h82};
    localparam logic [47:0] E_789000    = {8'h78, 8'h80, 8'h10, 8'hC0, 8'h40, 8'hC0};
    localparam logic [47:0] E_ALL_OFF   = {8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    localparam logic [47:0] E_BLINK0    = {8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'hFF};

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at frame edge %0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    // k is the edge number within a frame (1..48); output after edge k reflects cnt/idx of edge k-1
    task automatic check_edges(input int k0, input int k1, input logic [47:0] exp);
        logic [5:0] one;
        logic [5:0] esel;
        logic [7:0] eseg;
        int         slot;
        int         pos;
        one = 6'b00_0001;
        for (int k = k0; k <= k1; k++) begin
            @(posedge clk);
            #1;
            slot = (k - 1) / 8;
            pos  = (k - 1) % 8;
            eseg = exp[slot*8 +: 8];
            if ((pos < 2) || (eseg == 8'hFF)) begin
                esel = 6'h3F;
                eseg = 8'hFF;
            end else begin
                esel = ~(one << slot);
            end
            chk("sel", k, {26'd0, sel}, {26'd0, esel});
            chk("seg", k, {24'd0, seg}, {24'd0, eseg});
            chk("frame_done", k, {31'd0, frame_done}, {31'd0, (k == 48)});
        end
    endtask

    task automatic reset_with(input logic [23:0] d, input logic [5:0] m, input logic [5:0] p, input logic [5:0] b);
        @(negedge clk);
        rst_n    = 1'b0;
        din      = d;
        din_mask = m;
        din_dp   = p;
        blink_en = b;
        repeat (2) @(negedge clk);
        chk("rst_sel", 0, {26'd0, sel}, 32'h3F);
        chk("rst_seg", 0, {24'd0, seg}, 32'hFF);
        chk("rst_fd", 0, {31'd0, frame_done}, 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        din      = 24'h00_0000;
        din_mask = 6'h00;
        din_dp   = 6'h00;
        blink_en = 6'h00;

        vecs[0] = '{din: 24'h123456, mask: 6'h3F, dp: 6'h00, blink: 6'h00, exp: E_123456};
        vecs[1] = '{din: 24'h123456, mask: 6'h3F, dp: 6'h01, blink: 6'h00, exp: E_123456_DP};
        vecs[2] = '{din: 24'hABCDEF, mask: 6'h3F, dp: 6'h00, blink: 6'h00, exp: E_ABCDEF};
        vecs[3] = '{din: 24'h123456, mask: 6'b110011, dp: 6'h00, blink: 6'h00, exp: E_MASKED};
        vecs[4] = '{din: 24'h789000, mask: 6'h3F, dp: 6'b101010, blink: 6'h00, exp: E_789000};
        vecs[5] = '{din: 24'h123456, mask: 6'h00, dp: 6'h3F, blink: 6'h3F, exp: E_ALL_OFF};

        // Two frames per vector: first frame after release, then steady state
        for (int v = 0; v < 6; v++) begin
            reset_with(vecs[v].din, vecs[v].mask, vecs[v].dp, vecs[v].blink);
            check_edges(1, 48, vecs[v].exp);
            check_edges(1, 48, vecs[v].exp);
        end

        // Input change mid-frame only shows from the next frame onward
        reset_with(24'h123456, 6'h3F, 6'h00, 6'h00);
        check_edges(1, 20, E_123456);
        din = 24'hABCDEF;
        check_edges(21, 48, E_123456);
        check_edges(1, 48, E_ABCDEF);

        // Digit 0 blinks: lit, lit, blank, blank, lit, lit
        reset_with(24'h123456, 6'h3F, 6'h00, 6'h01);
        for (int f = 0; f < 6; f++) begin
            check_edges(1, 48, ((f == 2) || (f == 3)) ? E_BLINK0 : E_123456);
        end

        // Reset during slot 3 blanks at once; restart samples the new inputs
        reset_with(24'h123456, 6'h3F, 6'h00, 6'h00);
        check_edges(1, 28, E_123456);
        chk("pre_rst_sel", 28, {26'd0, sel}, 32'h37);
        din = 24'hABCDEF;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_sel", 0, {26'd0, sel}, 32'h3F);
        chk("async_seg", 0, {24'd0, seg}, 32'hFF);
        chk("async_fd", 0, {31'd0, frame_done}, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_edges(1, 48, E_ABCDEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter DIGIT_CYC, default 50_000; clk cycles per digit slot (1 ms at 50 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 500; blanked cycles at the start of each slot (anti-ghosting); constraint 1 <= BLANK_CYC < DIGIT_CYC.
REQ-003 SHALL have parameter BLINK_FRAMES, default 83; frames per blink half-period.
REQ-004 clk  input  1  system clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 din  input  24  six hex nibbles; din[4i+3:4i] is digit i; digit 5 (din[23:20]) is leftmost.
REQ-007 din_mask  input  6  bit i=1 enables digit i.
REQ-008 din_dp  input  6  bit i=1 lights the decimal point of digit i.
REQ-009 blink_en  input  6  bit i=1 makes digit i blink.
REQ-010 sel  output  6  digit select, active-low, registered.
REQ-011 seg  output  8  segments {dp,g,f,e,d,c,b,a}, active-low, registered.
REQ-012 frame_done  output  1  one-cycle pulse at the end of each 6-digit frame, registered.

Function
REQ-013 SHALL hold slot counter cnt (0..DIGIT_CYC-1) and digit index idx (0..5); cnt increments every cycle; on cnt==DIGIT_CYC-1, cnt wraps to 0 and idx advances 0->1->...->5->0.
REQ-014 SHALL copy din, din_mask, din_dp, blink_en into shadow registers on every edge where cnt==0 && idx==0, including the first such cycle after reset release; inputs are ignored at all other times (no mid-frame tearing).
REQ-015 Per cycle, SHALL compute blank = (cnt < BLANK_CYC) || !mask_s[idx] || (blink_s[idx] && phase).
REQ-016 On blank, next sel = 6'h3F and next seg = 8'hFF.
REQ-017 Otherwise, next sel = ~(6'b1 << idx), next seg[6:0] = decode(shadow nibble idx), next seg[7] = ~dp_s[idx].
REQ-018 decode (active-low, g..a), 0-F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, 7-bit).
REQ-019 Output latency: sel/seg SHALL reflect the cnt/idx/shadow/phase state of the previous cycle (one register stage); at most one sel bit is low at any time.
REQ-020 frame_done SHALL be 1 for exactly one cycle, the cycle after cnt==DIGIT_CYC-1 && idx==5.
REQ-021 Frame counter fcnt (0..BLINK_FRAMES-1) SHALL increment at each frame end; on wrap it SHALL toggle phase; blink period = 2*BLINK_FRAMES frames.
REQ-022 A masked-off or blink-blanked digit SHALL still consume its full slot; frame length is always 6*DIGIT_CYC cycles.
REQ-023 Counter widths SHALL be sized with $clog2 of the respective parameters; no overflow at default or test values.

Reset
REQ-024 While rst_n=0 (asynchronous): sel=6'h3F, seg=8'hFF, frame_done=0, cnt=0, idx=0, fcnt=0, phase=0, all shadow registers=0 (all digits disabled).
REQ-025 Reset asserted mid-frame SHALL blank outputs immediately; after release, scanning restarts at idx 0 with a fresh shadow load.

Verification (DIGIT_CYC=8, BLANK_CYC=2, BLINK_FRAMES=2)
REQ-026 Reset: hold rst_n=0 -> sel=3F, seg=FF, frame_done=0; release -> first frame_done pulse 48 cycles after the first active edge.
REQ-027 Display: din=24'h123456, din_mask=3F, din_dp=0, blink_en=0 -> slot 0 output cycles 3..8: sel=3E, seg=82 (the slot's first two output cycles are 3F/FF); slot 5: sel=1F, seg=F9; din_dp=01 -> slot 0 seg=02.
REQ-028 No tearing: change din to 24'hABCDEF during slot 2 -> rest of the frame shows 123456; next frame shows digit 0 seg=8E, digit 5 seg=88.
REQ-029 Mask: din_mask=6'b110011 -> slots 2 and 3 output sel=3F/seg=FF for all 8 cycles; frame_done spacing stays 48 cycles.
REQ-030 Blink: blink_en=01, din_mask=3F -> digit 0 lit in frames 0-1, blank in frames 2-3, lit in frames 4-5; digits 1-5 lit throughout.
REQ-031 Mid-frame reset: assert rst_n during slot 3 -> sel=3F the same cycle; after release, the next lit digit is digit 0, using values sampled at restart.
